adder_scheduler: RTL
====================

# adder_scheduler

Round-robin scheduler that shares one N-bit parallel adder between NREQ requesters. Each requester presents an operand pair and a request. The scheduler grants one requester at a time, captures its operands, and runs them through the adder. It then returns the registered sum and carry over a valid/ready response channel tagged with the requester ID. The block sits between client blocks and the team's single combinational adder datapath, and is its only user.

## Interface
- N, 4, operand/sum width in bits (≥1)
- NREQ, 4, number of requesters (2..16); IW = $clog2(NREQ)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*N  operand A, requester i at bits [i*N +: N]
- b_in  in  NREQ*N  operand B, same packing
- gnt  out  NREQ  one-hot grant, high for exactly one cycle per accepted request
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IW  index of requester owning the response
- rsp_sum  out  N  A+B modulo 2^N
- rsp_carry  out  1  carry out of bit N-1
- op_count  out  16  completed responses, wraps 16'hFFFF→0

## Operation
- FSM states: IDLE, ADD, RESP.
- **IDLE**
  - If req ≠ 0: select the winner as the first set bit searching upward from ptr, wrapping at NREQ.
  - On that edge: latch a_in/b_in slices of the winner into op_a/op_b, latch the winner into id_r, set gnt to one-hot(winner), set ptr = (winner+1) mod NREQ, go to ADD.
  - If req = 0: stay in IDLE, gnt = 0.
- **ADD**
  - gnt is high this cycle only.
  - The adder sees op_a/op_b with carry-in 0.
  - On the edge: load rsp_sum, rsp_carry, rsp_id ← id_r; set rsp_valid = 1; clear gnt; go to RESP.
- **RESP**
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: clear rsp_valid, increment op_count, go to IDLE. rsp_sum/carry/id keep their last values.
- Requesters must deassert req in the cycle after seeing gnt. A req still high when IDLE is re-entered is a new request.
- No requests are accepted outside IDLE. req changes during ADD/RESP are ignored.
- Operand slices must be stable from req assertion until gnt. Only the winner's slices are sampled.
- Arithmetic: {rsp_carry, rsp_sum} = op_a + op_b, computed at N+1 bits with no truncation of the carry. rsp_carry = 1 exactly when the true sum ≥ 2^N.

## Timing
- **Reset values** (asserted asynchronously, take effect immediately):
  - state=IDLE, ptr=0, gnt=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, op_count=0, op_a=op_b=0, id_r=0.
- **Reset mid-operation:** an in-flight operation is dropped and no response is produced. After release, arbitration restarts from ptr=0.
- **Latency:**
  - req seen in IDLE at edge k.
  - gnt high in cycle k+1.
  - rsp_valid high from cycle k+2.
- **Throughput:** with rsp_ready held 1 and continuous requests, one operation per 3 cycles.
- **Simultaneous requests:** exactly one grant per IDLE visit. ptr guarantees every requester is granted within NREQ operations.
- **rsp_ready high outside RESP:** ignored.

## Structure
- Package adder_sched_pkg holds:
  - state enum: IDLE=2'd0, ADD=2'd1, RESP=2'd2
  - localparams N_DEF=4, NREQ_DEF=4, CNT_W=16
  - round-robin pick function (req, ptr → winner index, found flag)
- Sub-module: one instance of the team's existing parallel_adder with n=N, fed from op_a/op_b, carry-in tied to 0. This instance is the only adder in the block.
- All other logic lives in adder_scheduler: FSM, ptr, operand/result registers, op_count.

## Test plan
- **Single request:** req=4'b0100, A2=4'h9, B2=4'h8 → gnt=4'b0100 for one cycle; then rsp_valid=1, rsp_id=2, rsp_sum=4'h1, rsp_carry=1; op_count=1 after handshake.
- **All requesting:** after reset, req=4'b1111 held, rsp_ready=1 → grant order 0,1,2,3,0, one grant every 3 cycles.
- **Backpressure:** rsp_ready=0 for 5 cycles while req=4'b0011 → rsp_* stable, no gnt. After rsp_ready=1, the next grant goes to requester (previous winner+1).
- **Boundaries:**
  - A=4'hF, B=4'h1 → sum 4'h0, carry 1.
  - A=4'h0, B=4'h0 → sum 0, carry 0.
  - A=4'hF, B=4'hF → sum 4'hE, carry 1.
- **Reset mid-RESP:** assert rst while rsp_valid=1 → rsp_valid=0 and op_count=0 without waiting for a clock edge. Next req=4'b1010 → gnt=4'b0010.

Source files
------------

// File: rtl/adder_scheduler_pkg.sv
// adder_sched_pkg: shared state encoding, defaults and round-robin pick for adder_scheduler
package adder_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, RESP = 2'd2} state_t;
  localparam int N_DEF = 4;
  localparam int NREQ_DEF = 4;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Scanning downward lets the smallest offset from ptr overwrite the rest
  function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int nreq);
    pick_t p;
    p = '0;
    for (int i = 15; i >= 0; i--)
      if (i < nreq && req[(int'(ptr) + i) % nreq]) begin
        p.found = 1'b1;
        p.idx   = 4'((int'(ptr) + i) % nreq);
      end
    return p;
  endfunction
endpackage

// File: rtl/adder_scheduler_if.sv
// adder_scheduler_if: requester bus and response channel of adder_scheduler
interface adder_scheduler_if import adder_sched_pkg::*; #(parameter int N = N_DEF, parameter int NREQ = NREQ_DEF);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [NREQ*N-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_carry;
  logic [CNT_W-1:0]  op_count;
  modport master (output req, a_in, b_in, rsp_ready,
                  input gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, op_count);
  modport slave  (input req, a_in, b_in, rsp_ready,
                  output gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, op_count);
endinterface

// File: rtl/parallel_adder.sv
// parallel_adder: combinational n-bit adder with carry in and carry out
module parallel_adder #(parameter int n = 4) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin sharing of one parallel_adder among NREQ requesters
module adder_scheduler import adder_sched_pkg::*; #(parameter int N = N_DEF, parameter int NREQ = NREQ_DEF) (
  input logic clk,
  input logic rst,
  adder_scheduler_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_r;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  sum;
  logic          carry;
  pick_t         pick;
  logic [4:0]    nx;
  assign pick = rr_pick(16'(bus.req), 4'(ptr), NREQ);
  assign nx   = {1'b0, pick.idx} + 5'd1;
  parallel_adder #(.n(N)) u_add (.a(op_a), .b(op_b), .cin(1'b0), .sum(sum), .cout(carry));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      id_r          <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_carry <= 1'b0;
      bus.op_count  <= '0;
    end else
      case (state)
        IDLE:
          if (pick.found) begin
            op_a    <= bus.a_in[pick.idx*N +: N];
            op_b    <= bus.b_in[pick.idx*N +: N];
            id_r    <= IW'(pick.idx);
            bus.gnt <= NREQ'(1) << pick.idx;
            ptr     <= (nx == 5'(NREQ)) ? '0 : IW'(nx);
            state   <= ADD;
          end else
            bus.gnt <= '0;
        ADD: begin
          bus.rsp_sum   <= sum;
          bus.rsp_carry <= carry;
          bus.rsp_id    <= id_r;
          bus.rsp_valid <= 1'b1;
          bus.gnt       <= '0;
          state         <= RESP;
        end
        RESP:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.op_count  <= bus.op_count + 1'b1;
            state         <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
